// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types and constants for the sequential comparator
package cmp_pkg;

  typedef enum logic [1:0] {IDLE, CMP, DONE} cmp_state_t;

  localparam NIBBLE_W = 4;

endpackage

// File: rtl/cmp4.sv
// rtl/cmp4.sv - combinational 4-bit unsigned magnitude comparator
//
// Ports:
//   a, b     : 4-bit unsigned operands
//   Greater  : a > b
//   Less     : a < b
//   (equality is implied when neither output is set)
module cmp4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       Greater,
  output logic       Less
);

  assign Greater = (a > b);
  assign Less    = (a < b);

endmodule

// File: rtl/cmp_seq_ctrl.sv
// rtl/cmp_seq_ctrl.sv - multi-cycle wide comparator built on one shared cmp4
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start, ready      : request handshake; start is taken only while ready=1
//   a, b              : WIDTH-bit unsigned operands, captured on accepted start
//   done              : one-cycle pulse when results update
//   Greater/Less/Equal: result flags, held until the next compare completes
//   steps             : nibbles examined for the last result (1..NIB)
module cmp_seq_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,        // multiple of 4, at least 4
  parameter int NIB   = WIDTH / 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic                       ready,
  output logic                       done,
  output logic                       Greater,
  output logic                       Less,
  output logic                       Equal,
  output logic [$clog2(NIB+1)-1:0]   steps
);

  localparam int SW = $clog2(NIB + 1);
  // A single-nibble build still needs a 1-bit index register.
  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

  cmp_state_t       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx;
  logic [SW-1:0]    cnt;

  logic [WIDTH-1:0]    a_sh;
  logic [WIDTH-1:0]    b_sh;
  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic                nib_gt;
  logic                nib_lt;
  logic [SW-1:0]       cnt_next;

  // Nibble select on the latched operands: shift the chosen nibble to the
  // bottom so the index never has to match the vector's select width.
  assign a_sh  = a_q >> {idx, 2'b00};
  assign b_sh  = b_q >> {idx, 2'b00};
  assign a_nib = a_sh[NIBBLE_W-1:0];
  assign b_nib = b_sh[NIBBLE_W-1:0];

  cmp4 u_cmp4 (
    .a       (a_nib),
    .b       (b_nib),
    .Greater (nib_gt),
    .Less    (nib_lt)
  );

  // cnt counts completed CMP cycles; the current cycle is one more.
  assign cnt_next = cnt + SW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ready   <= 1'b1;
      done    <= 1'b0;
      Greater <= 1'b0;
      Less    <= 1'b0;
      Equal   <= 1'b0;
      steps   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      idx     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            idx   <= IW'(NIB - 1);
            cnt   <= '0;
            ready <= 1'b0;
            state <= CMP;
          end
        end

        CMP: begin
          cnt <= cnt_next;
          if (nib_gt || nib_lt) begin
            Greater <= nib_gt;
            Less    <= nib_lt;
            Equal   <= 1'b0;
            steps   <= cnt_next;
            done    <= 1'b1;
            state   <= DONE;
          end else if (idx == '0) begin
            Greater <= 1'b0;
            Less    <= 1'b0;
            Equal   <= 1'b1;
            steps   <= cnt_next;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            idx <= idx - IW'(1);
          end
        end

        DONE: begin
          // Results stay registered; only the pulse and handshake change.
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// tb/tb_cmp_seq_ctrl.sv - directed self-checking bench for cmp_seq_ctrl
module tb_cmp_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  // 16-bit instance
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        ready, done, Greater, Less, Equal;
  logic [2:0]  steps;

  // 4-bit instance for the exhaustive single-nibble sweep
  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0;
  logic [3:0]  b4 = '0;
  logic        ready4, done4, Greater4, Less4, Equal4;
  logic [0:0]  steps4;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  cmp_seq_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .ready(ready), .done(done), .Greater(Greater), .Less(Less),
    .Equal(Equal), .steps(steps)
  );

  cmp_seq_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4),
    .ready(ready4), .done(done4), .Greater(Greater4), .Less(Less4),
    .Equal(Equal4), .steps(steps4)
  );

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ready, done, Greater, Less, Equal, steps} !== 8'b1000_0000)
      $display("FAIL reset16: got %b required 10000000",
               {ready, done, Greater, Less, Equal, steps});
    else passed++;
    checks++;
    if ({ready4, done4, Greater4, Less4, Equal4, steps4} !== 6'b100000)
      $display("FAIL reset4: got %b required 100000",
               {ready4, done4, Greater4, Less4, Equal4, steps4});
    else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Caller is at a negedge with ready=1; returns at the negedge where ready
  // has come back, so calls can be chained back to back.
  task automatic run_cmp(input logic [15:0] ta, input logic [15:0] tb_v,
                         input int n, input logic eg, input logic el,
                         input logic ee, input string name);
    logic [5:0] prev;
    logic       busy_ok;
    int         done_at;
    prev    = {Greater, Less, Equal, steps};
    busy_ok = 1'b1;
    done_at = 0;
    a = ta; b = tb_v; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // cycle t+1: previous results must still be held
    checks++;
    if ({Greater, Less, Equal, steps} !== prev)
      $display("FAIL %s_hold: got %b required %b", name,
               {Greater, Less, Equal, steps}, prev);
    else passed++;
    for (int k = 1; k <= 12; k++) begin
      if (ready !== 1'b0) busy_ok = 1'b0;
      if (done === 1'b1) begin
        done_at = k;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (done_at != n + 1)
      $display("FAIL %s_latency: done in cycle t+%0d required t+%0d", name, done_at, n + 1);
    else passed++;
    checks++;
    if (!busy_ok) $display("FAIL %s_busy: ready seen high while busy, required 0", name);
    else passed++;
    checks++;
    if ({Greater, Less, Equal} !== {eg, el, ee})
      $display("FAIL %s_result: GLE got %b required %b", name,
               {Greater, Less, Equal}, {eg, el, ee});
    else passed++;
    checks++;
    if (steps !== 3'(n))
      $display("FAIL %s_steps: got %0d required %0d", name, steps, n);
    else passed++;
    @(negedge clk);
    checks++;
    if ({ready, done} !== 2'b10)
      $display("FAIL %s_release: ready,done got %b required 10", name, {ready, done});
    else passed++;
  endtask

  task automatic test_basic;
    run_cmp(16'h1234, 16'h1234, 4, 1'b0, 1'b0, 1'b1, "equal");
    run_cmp(16'h8000, 16'h7FFF, 1, 1'b1, 1'b0, 1'b0, "msb_gt");
    run_cmp(16'h12A4, 16'h12B0, 3, 1'b0, 1'b1, 1'b0, "nib1_lt");
    run_cmp(16'h0000, 16'h0001, 4, 1'b0, 1'b1, 1'b0, "lsb_lt");
    run_cmp(16'hFFFF, 16'h0000, 1, 1'b1, 1'b0, 1'b0, "max_gt");
  endtask

  task automatic test_back_to_back;
    run_cmp(16'hABCD, 16'hABC0, 4, 1'b1, 1'b0, 1'b0, "b2b_1");
    run_cmp(16'h0F00, 16'h0E00, 2, 1'b1, 1'b0, 1'b0, "b2b_2");
    run_cmp(16'h0000, 16'h0000, 4, 1'b0, 1'b0, 1'b1, "b2b_3");
  endtask

  task automatic test_start_ignored;
    int         ndone;
    int         done_at;
    logic [5:0] res;
    ndone = 0; done_at = 0; res = '0;
    a = 16'h0001; b = 16'h0002; start = 1'b1;
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 2; k <= 12; k++) begin
      if (done === 1'b1) begin
        ndone++;
        if (done_at == 0) begin
          done_at = k;
          res = {Greater, Less, Equal, steps};
        end
      end
      @(negedge clk);
    end
    checks++;
    if (ndone != 1 || done_at != 5)
      $display("FAIL ignored_done: %0d pulses at t+%0d required 1 at t+5", ndone, done_at);
    else passed++;
    checks++;
    if (res !== 6'b010_100)
      $display("FAIL ignored_result: GLE,steps got %b required 010100", res);
    else passed++;
  endtask

  task automatic test_reset_abort;
    logic seen;
    seen = 1'b0;
    a = 16'h5555; b = 16'h5555; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    if (done === 1'b1) seen = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({ready, done, Greater, Less, Equal, steps} !== 8'b1000_0000)
      $display("FAIL abort_state: got %b required 10000000",
               {ready, done, Greater, Less, Equal, steps});
    else passed++;
    for (int k = 4; k <= 10; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) $display("FAIL abort_nodone: done pulse seen, required none");
    else passed++;
  endtask

  task automatic test_sweep4;
    int bad;
    bad = 0;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        logic [5:0] exp_v;
        a4 = 4'(ai); b4 = 4'(bi); start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        checks++;
        if (done4 !== 1'b0) begin
          bad++;
          $display("FAIL sweep_early a=%0d b=%0d: done got %b required 0", ai, bi, done4);
        end else passed++;
        @(negedge clk);
        exp_v = {1'b0, 1'b1, ai > bi, ai < bi, ai == bi, 1'b1};
        checks++;
        if ({ready4, done4, Greater4, Less4, Equal4, steps4} !== exp_v) begin
          bad++;
          $display("FAIL sweep a=%0d b=%0d: rdy,done,GLE,steps got %b required %b",
                   ai, bi, {ready4, done4, Greater4, Less4, Equal4, steps4}, exp_v);
        end else passed++;
        @(negedge clk);
        checks++;
        if ({ready4, done4} !== 2'b10) begin
          bad++;
          $display("FAIL sweep_release a=%0d b=%0d: got %b required 10", ai, bi, {ready4, done4});
        end else passed++;
        if (bad > 10) return;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_ignored();
    test_reset_abort();
    test_sweep4();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
